multdiv_sequencer: RTL
======================

# multdiv_sequencer

Multi-cycle sequencer that places the shared multiplier/divider unit alongside the single-cycle decode/control path. It detects R-type `mul`/`div` in execute and latches operands and destination. It then pulses the unit's start control, stalls the pipeline until the result is ready, and performs the register-file writeback. On exception it writes the status code to `$rstatus` instead of `rd`.

## Interface
Parameters:
- `CNT_W`, 6: width of the busy-cycle counter.
- `TIMEOUT`, 40: busy cycles before a forced exception (used only with the timeout feature; must be < 2^CNT_W).

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `insn_valid`  in  1  execute-stage instruction is valid.
- `opCode`  in  5  instruction [31:27].
- `aluOp`  in  5  instruction [6:2].
- `rd`  in  5  destination register.
- `operandA`, `operandB`  in  32  register-file read data for `rs` and `rt`.
- `md_resultRDY`  in  1  unit result valid.
- `md_exception`  in  1  unit overflow or divide-by-zero; qualified by `md_resultRDY`.
- `md_result`  in  32  unit result.
- `ctrl_MULT`, `ctrl_DIV`  out  1  one-cycle start pulses to the unit.
- `md_opA`, `md_opB`  out  32  latched operands, held stable from START through BUSY.
- `stall`  out  1  freezes PC and upstream pipeline registers.
- `wb_we`  out  1  sequencer writeback valid; overrides the normal writeback port that cycle.
- `wb_reg`  out  5  writeback register.
- `wb_data`  out  32  writeback data.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Decode: `is_mul` = `opCode`=00000 & `aluOp`=00110. `is_div` = `opCode`=00000 & `aluOp`=00111. `md_req` = `insn_valid` & (`is_mul` | `is_div`).
- States: IDLE, START, BUSY, WB.
  - IDLE → START on `md_req`. Latch `operandA`/`operandB` into `md_opA`/`md_opB`, latch `rd`, and latch the op kind (mul/div).
  - START: assert `ctrl_MULT` or `ctrl_DIV` for exactly this cycle. Clear the counter. Go to BUSY.
  - BUSY: on `md_resultRDY` → WB, capturing result and exception flag. Otherwise stay and increment the counter, saturating.
  - WB: drive writeback for one cycle, then → IDLE.
- Writeback in WB:
  - No exception: `wb_reg` = latched `rd`, `wb_data` = captured result, `wb_we` = (`rd` ≠ 0).
  - Exception: `wb_reg` = 30, `wb_data` = 4 (mul) or 5 (div), `wb_we` = 1.
- `stall` = (IDLE & `md_req`) | START | BUSY. It is low in WB, so the pipeline advances the same cycle the writeback commits.
- `md_resultRDY` is ignored in IDLE, START and WB.
- `md_exception` is ignored unless `md_resultRDY` is high. If both are high, the exception path wins.
- A new `md_req` in the WB cycle is an instruction behind the completing one. It is accepted only on the following cycle in IDLE, because the pipeline register updates at the end of WB.

## Timing
- Reset values:
  - Registers: state IDLE, counter 0, latched operands/rd/kind 0.
  - Outputs: `ctrl_MULT` 0, `ctrl_DIV` 0, `wb_we` 0, `wb_reg` 0, `wb_data` 0, `busy` 0, `md_opA`/`md_opB` 0.
  - `stall` is 0 unless `md_req` is present (combinational from IDLE).
- Reset mid-operation returns to IDLE next edge. No pulse or writeback is issued afterwards, and a late `md_resultRDY` is ignored.
- Latency: request seen at cycle 0, START pulse at 1, BUSY from 2. If RDY arrives at cycle k ≥ 2, WB is at k+1.
- The start pulse is never asserted more than once per instruction.

## Configuration
- `MULTDIV_TIMEOUT_EN`:
  - Defined: when the BUSY counter reaches `TIMEOUT` without `md_resultRDY`, go to WB as an exception (code 4/5 to reg 30). An RDY arriving on that same cycle takes precedence over the timeout.
  - Undefined: no counter comparison; BUSY waits indefinitely.

## Structure
- Shared package `md_pkg`:
  - Opcode constant `OP_RTYPE` and ALU-op constants `ALU_MUL`/`ALU_DIV`.
  - Register constant `REG_RSTATUS` = 30 and status codes `RSTATUS_MUL` = 4, `RSTATUS_DIV` = 5.
  - State enum typedef.
- One combinational sub-module, `md_decode`, produces `is_mul`/`is_div`. The FSM, latches and counter stay in `multdiv_sequencer`.

## Test plan
- `mul`, rd=5, A=7, B=6; RDY with 42 at cycle 18. Required: `ctrl_MULT` pulse at cycle 1 only; `stall` high cycles 0–18; WB at cycle 19 writes reg5=42.
- `div`, rd=3, A=9, B=0; RDY with exception at cycle 4. Required: WB at cycle 5 writes reg30=5, `wb_we`=1.
- `mul` with rd=0, valid result. Required: WB cycle has `wb_we`=0; FSM returns to IDLE.
- Reset asserted in BUSY, then RDY arrives. Required: IDLE, no `wb_we`, `stall` 0 with `insn_valid`=0.
- Back-to-back `mul`, `div`. Required: second accepted only after WB; exactly one `ctrl_MULT` and one `ctrl_DIV` pulse.
- With `MULTDIV_TIMEOUT_EN`, `TIMEOUT`=40, `div` with no RDY. Required: WB at BUSY count 40 writes reg30=5. Without the macro: still BUSY at cycle 200.

Source files
------------

// File: rtl/md_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
// Used by md_decode and multdiv_sequencer (optional MULTDIV_TIMEOUT_EN build).
package md_pkg;

    // Instruction field encodings for the R-type mul/div instructions
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Exception reporting: status register index and codes written to it
    localparam logic [4:0]  REG_RSTATUS = 5'd30;
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WB    = 2'd3
    } md_state_e;

    // Kind of operation latched at acceptance
    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } md_kind_e;

    // Status code reported in $rstatus for a failed operation of the given kind
    function automatic logic [31:0] rstatus_code(input md_kind_e kind);
        return (kind == KIND_DIV) ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational decode of the execute-stage instruction into mul/div flags.
module md_decode
    import md_pkg::*;
(
    input  logic [4:0] opCode,
    input  logic [4:0] aluOp,
    output logic       is_mul,
    output logic       is_div
);

    logic is_rtype;

    // Both instructions are R-type; the ALU op field selects which one
    always_comb begin
        is_rtype = (opCode == OP_RTYPE);
        is_mul   = is_rtype && (aluOp == ALU_MUL);
        is_div   = is_rtype && (aluOp == ALU_DIV);
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle sequencer for the shared multiplier/divider unit.
// Accepts mul/div from execute, pulses the unit's start, stalls the pipeline
// until the result is ready and commits the writeback (or the $rstatus code
// on exception).
// Optional feature: define MULTDIV_TIMEOUT_EN to force an exception after
// TIMEOUT busy cycles without a result.
module multdiv_sequencer
    import md_pkg::*;
#(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        insn_valid,
    input  logic [4:0]  opCode,
    input  logic [4:0]  aluOp,
    input  logic [4:0]  rd,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    md_state_e        state_q, state_d;
    md_kind_e         kind_q;
    logic [4:0]       rd_q;
    logic [31:0]      opa_q, opb_q;
    logic [31:0]      res_q;
    logic             exc_q;
    logic [CNT_W-1:0] cnt_q;

    logic is_mul, is_div, md_req;
    logic accept;      // IDLE and a request present: latch operands
    logic capture;     // BUSY and result ready: latch result/exception
    logic force_exc;   // BUSY timed out: report an exception

    md_decode u_decode (
        .opCode (opCode),
        .aluOp  (aluOp),
        .is_mul (is_mul),
        .is_div (is_div)
    );

    assign md_req = insn_valid && (is_mul || is_div);

`ifdef MULTDIV_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    logic timeout_hit;
    assign timeout_hit = (cnt_q == TIMEOUT_CNT);
`else
    // Counter is still maintained but nothing compares it in this build
    logic unused_cnt;
    assign unused_cnt = ^{cnt_q, TIMEOUT};
`endif

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and all FSM-driven outputs
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        force_exc = 1'b0;
        stall     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        wb_we     = 1'b0;
        wb_reg    = 5'd0;
        wb_data   = 32'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (md_req) begin
                    accept  = 1'b1;
                    stall   = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                stall     = 1'b1;
                ctrl_MULT = (kind_q == KIND_MUL);
                ctrl_DIV  = (kind_q == KIND_DIV);
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (md_resultRDY) begin
                    capture = 1'b1;
                    state_d = ST_WB;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (timeout_hit) begin
                    force_exc = 1'b1;
                    state_d   = ST_WB;
                end
`endif
            end
            ST_WB: begin
                // Pipeline advances this cycle; a request seen now belongs to
                // the next instruction and is taken from IDLE
                if (exc_q) begin
                    wb_we   = 1'b1;
                    wb_reg  = REG_RSTATUS;
                    wb_data = rstatus_code(kind_q);
                end else begin
                    wb_we   = (rd_q != 5'd0);
                    wb_reg  = rd_q;
                    wb_data = res_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand/destination latches, result capture and busy-cycle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            kind_q <= KIND_MUL;
            rd_q   <= 5'd0;
            opa_q  <= 32'd0;
            opb_q  <= 32'd0;
            res_q  <= 32'd0;
            exc_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                kind_q <= is_div ? KIND_DIV : KIND_MUL;
                rd_q   <= rd;
                opa_q  <= operandA;
                opb_q  <= operandB;
            end

            if (state_q == ST_START) begin
                cnt_q <= '0;
            end else if ((state_q == ST_BUSY) && !md_resultRDY && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (capture) begin
                res_q <= md_result;
                exc_q <= md_exception;
            end else if (force_exc) begin
                res_q <= 32'd0;
                exc_q <= 1'b1;
            end
        end
    end

    assign md_opA = opa_q;
    assign md_opB = opb_q;
    assign busy   = (state_q != ST_IDLE);

endmodule
